// File: rtl/sensor_scanner.sv
// sensor_scanner: dwell-timed auto/manual sensor sampler with sticky threshold alarms and max tracking
module sensor_scanner #(
    parameter int N_SENSORS = 8,
    parameter int WIDTH = 4,
    parameter int DWELL = 2,
    localparam int SW = $clog2(N_SENSORS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_SENSORS*WIDTH-1:0]   sensors,
    input  logic                         mode,
    input  logic [SW-1:0]                sel,
    input  logic [WIDTH-1:0]             threshold,
    input  logic                         clear_alarm,
    output logic [WIDTH-1:0]             data,
    output logic [SW-1:0]                channel,
    output logic                         valid,
    output logic [N_SENSORS-1:0]         alarm,
    output logic [WIDTH-1:0]             max_value,
    output logic [SW-1:0]                max_channel
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    logic [CW-1:0] cnt;
    logic [SW-1:0] ptr, ch;
    logic [WIDTH-1:0] rd [N_SENSORS];
    logic [WIDTH-1:0] val;
    logic sample, load;
    logic [N_SENSORS-1:0] alarm_nxt;
    for (genvar i = 0; i < N_SENSORS; i++) begin : g_rd
        assign rd[i] = sensors[i*WIDTH +: WIDTH];
    end
    // a coincident clear wipes the old state first, so the sample always loads max
    always_comb begin
        sample = cnt == CW'(DWELL - 1);
        ch = mode ? ptr : ({1'b0, sel} < (SW+1)'(N_SENSORS) ? sel : '0);
        val = rd[ch];
        load = sample && (clear_alarm || val > max_value);
        alarm_nxt = (clear_alarm ? '0 : alarm) | (N_SENSORS'(sample && val >= threshold) << ch);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ptr <= '0;
            data <= '0;
            channel <= '0;
            valid <= 1'b0;
            alarm <= '0;
            max_value <= '0;
            max_channel <= '0;
        end else begin
            cnt <= sample ? '0 : cnt + 1'b1;
            valid <= sample;
            alarm <= alarm_nxt;
            if (sample) begin
                data <= val;
                channel <= ch;
            end
            if (sample && mode)
                ptr <= ptr == SW'(N_SENSORS - 1) ? '0 : ptr + 1'b1;
            if (load) begin
                max_value <= val;
                max_channel <= ch;
            end else if (clear_alarm) begin
                max_value <= '0;
                max_channel <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sensor_scanner.sv
// tb_sensor_scanner: directed bench with per-instance sample scoreboards for three parameterisations
module tb_sensor_scanner;
    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;

    logic a_rst, a_mode, a_clr, a_valid;
    logic [31:0] a_sensors;
    logic [2:0] a_sel, a_channel, a_mch;
    logic [3:0] a_th, a_data, a_max;
    logic [7:0] a_alarm;

    logic b_rst, b_mode, b_clr, b_valid;
    logic [31:0] b_sensors;
    logic [2:0] b_sel, b_channel, b_mch;
    logic [3:0] b_th, b_data, b_max;
    logic [7:0] b_alarm;

    logic c_rst, c_mode, c_clr, c_valid;
    logic [19:0] c_sensors;
    logic [2:0] c_sel, c_channel, c_mch;
    logic [3:0] c_th, c_data, c_max;
    logic [4:0] c_alarm;

    sensor_scanner #(.N_SENSORS(8), .WIDTH(4), .DWELL(2)) dut_a (
        .clk(clk), .reset(a_rst), .sensors(a_sensors), .mode(a_mode), .sel(a_sel),
        .threshold(a_th), .clear_alarm(a_clr), .data(a_data), .channel(a_channel),
        .valid(a_valid), .alarm(a_alarm), .max_value(a_max), .max_channel(a_mch)
    );
    sensor_scanner #(.N_SENSORS(8), .WIDTH(4), .DWELL(3)) dut_b (
        .clk(clk), .reset(b_rst), .sensors(b_sensors), .mode(b_mode), .sel(b_sel),
        .threshold(b_th), .clear_alarm(b_clr), .data(b_data), .channel(b_channel),
        .valid(b_valid), .alarm(b_alarm), .max_value(b_max), .max_channel(b_mch)
    );
    sensor_scanner #(.N_SENSORS(5), .WIDTH(4), .DWELL(1)) dut_c (
        .clk(clk), .reset(c_rst), .sensors(c_sensors), .mode(c_mode), .sel(c_sel),
        .threshold(c_th), .clear_alarm(c_clr), .data(c_data), .channel(c_channel),
        .valid(c_valid), .alarm(c_alarm), .max_value(c_max), .max_channel(c_mch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic a_restart;
        a_rst = 1'b1;
        tick(1);
        a_rst = 1'b0;
    endtask

    // every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (a_valid) begin
            check("a_sb_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                check("a_channel", a_channel, ea.ch);
                check("a_data", a_data, ea.d);
            end
        end
        if (b_valid) begin
            check("b_sb_nonempty", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                check("b_channel", b_channel, eb.ch);
                check("b_data", b_data, eb.d);
            end
        end
        if (c_valid) begin
            check("c_sb_nonempty", qc.size() != 0, 1);
            if (qc.size() != 0) begin
                ec = qc.pop_front();
                check("c_channel", c_channel, ec.ch);
                check("c_data", c_data, ec.d);
            end
        end
    end

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
        a_mode = 1'b1; a_sel = '0; a_th = 4'd15;
        b_mode = 1'b0; b_sel = 3'd5; b_th = 4'd15;
        c_mode = 1'b1; c_sel = '0; c_th = 4'd15;
        for (int i = 0; i < 8; i++) a_sensors[i*4 +: 4] = 4'(i);
        for (int i = 0; i < 8; i++) b_sensors[i*4 +: 4] = i == 5 ? 4'hA : 4'(i);
        for (int i = 0; i < 5; i++) c_sensors[i*4 +: 4] = 4'(i + 1);
        tick(1);
        check("a_rst_data", a_data, 0);
        check("a_rst_channel", a_channel, 0);
        check("a_rst_valid", a_valid, 0);
        check("a_rst_alarm", a_alarm, 0);
        check("a_rst_max", a_max, 0);
        check("a_rst_mch", a_mch, 0);

        // auto sweep, channel i reads i
        for (int i = 0; i < 9; i++) qa.push_back({8'(i % 8), 8'(i % 8)});
        a_rst = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick(1);
            check("a_valid_pattern", a_valid, k % 2 == 0);
        end
        check("a_sweep_q_empty", qa.size(), 0);
        check("a_sweep_alarm", a_alarm, 0);
        check("a_sweep_max", a_max, 7);
        check("a_sweep_mch", a_mch, 7);

        // sticky alarms and clear
        a_th = 4'd9;
        for (int i = 0; i < 8; i++) begin
            a_sensors[i*4 +: 4] = i == 2 ? 4'd9 : i == 6 ? 4'd12 : 4'd3;
            qa.push_back({8'(i), 8'(i == 2 ? 9 : i == 6 ? 12 : 3)});
        end
        a_restart();
        tick(16);
        check("a_alarm_sweep", a_alarm, 8'b0100_0100);
        check("a_alarm_max", a_max, 12);
        check("a_alarm_mch", a_mch, 6);
        a_sensors = '0;
        for (int i = 0; i < 8; i++) qa.push_back({8'(i), 8'd0});
        tick(16);
        check("a_alarm_sticky", a_alarm, 8'b0100_0100);
        check("a_sticky_max", a_max, 12);
        a_clr = 1'b1;
        tick(1);
        a_clr = 1'b0;
        check("a_clear_alarm", a_alarm, 0);
        check("a_clear_max", a_max, 0);
        check("a_clear_mch", a_mch, 0);

        // clear coincident with the sample edge of channel 3
        a_th = 4'd10;
        a_sensors = '0;
        for (int i = 0; i < 3; i++) begin
            a_sensors[i*4 +: 4] = 4'd12;
            qa.push_back({8'(i), 8'd12});
        end
        a_sensors[12 +: 4] = 4'd11;
        qa.push_back({8'd3, 8'd11});
        a_restart();
        tick(6);
        check("a_pre_clr_alarm", a_alarm, 8'b0000_0111);
        check("a_pre_clr_max", a_max, 12);
        check("a_pre_clr_mch", a_mch, 0);
        tick(1);
        a_clr = 1'b1;
        tick(1);
        a_clr = 1'b0;
        check("a_coinc_alarm", a_alarm, 8'b0000_1000);
        check("a_coinc_max", a_max, 11);
        check("a_coinc_mch", a_mch, 3);

        // tie keeps the earlier channel
        a_th = 4'd15;
        for (int i = 0; i < 8; i++) begin
            a_sensors[i*4 +: 4] = (i == 1 || i == 4) ? 4'd13 : 4'd5;
            qa.push_back({8'(i), 8'((i == 1 || i == 4) ? 13 : 5)});
        end
        a_restart();
        tick(16);
        check("a_tie_max", a_max, 13);
        check("a_tie_mch", a_mch, 1);
        check("a_tie_alarm", a_alarm, 0);

        // asynchronous reset mid-sweep
        for (int i = 0; i < 8; i++) a_sensors[i*4 +: 4] = 4'(i);
        for (int i = 0; i < 5; i++) qa.push_back({8'(i), 8'(i)});
        a_restart();
        tick(10);
        check("a_mid_channel", a_channel, 4);
        #1 a_rst = 1'b1;
        #1;
        check("a_async_data", a_data, 0);
        check("a_async_channel", a_channel, 0);
        check("a_async_valid", a_valid, 0);
        check("a_async_alarm", a_alarm, 0);
        check("a_async_max", a_max, 0);
        check("a_async_mch", a_mch, 0);
        tick(1);
        qa.push_back({8'd0, 8'd0});
        a_rst = 1'b0;
        tick(1);
        check("a_rel_valid0", a_valid, 0);
        tick(1);
        check("a_rel_valid1", a_valid, 1);
        check("a_rel_channel", a_channel, 0);
        check("a_final_q_empty", qa.size(), 0);
        a_rst = 1'b1;

        // manual mode, DWELL=3, then back to auto from held ptr
        for (int i = 0; i < 4; i++) qb.push_back({8'd5, 8'hA});
        b_rst = 1'b0;
        tick(12);
        check("b_manual_q_empty", qb.size(), 0);
        check("b_manual_channel", b_channel, 5);
        b_mode = 1'b1;
        qb.push_back({8'd0, 8'd0});
        qb.push_back({8'd1, 8'd1});
        tick(6);
        check("b_auto_q_empty", qb.size(), 0);
        check("b_alarm", b_alarm, 0);
        b_rst = 1'b1;

        // DWELL=1, N=5: continuous strobe and 4->0 wrap
        for (int i = 0; i < 7; i++) qc.push_back({8'(i % 5), 8'(i % 5 + 1)});
        c_rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check("c_valid_cont", c_valid, 1);
        end
        check("c_sweep_q_empty", qc.size(), 0);
        check("c_max", c_max, 5);
        check("c_mch", c_mch, 4);
        #1 c_rst = 1'b1;
        #1;
        check("c_async_valid", c_valid, 0);
        check("c_async_data", c_data, 0);
        check("c_async_max", c_max, 0);
        tick(1);
        qc.push_back({8'd0, 8'd1});
        c_rst = 1'b0;
        tick(1);
        check("c_rel_valid", c_valid, 1);
        // out-of-range manual select falls back to channel 0
        c_mode = 1'b0;
        c_sel = 3'd6;
        for (int i = 0; i < 3; i++) qc.push_back({8'd0, 8'd1});
        tick(3);
        check("c_sel_oor_q_empty", qc.size(), 0);
        c_rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
